rgb_depth_controller: RTL and testbench

Parametrised per-channel colour-depth controller for the VGA pipeline. It holds one WIDTH-bit intensity register per colour channel and steps each one up or down from user step requests, with hold-to-repeat, wrap/saturate mode and a parallel preset load. Its output bus feeds the pixel colour path directly. It generalises the fixed 3×3-bit RGB up/down counter bank to CHANNELS×WIDTH.

---
 rtl/rgb_depth_controller_if.sv | 26 ++
 rtl/rgb_depth_controller.sv | 145 ++++++++++++++
 tb/tb_rgb_depth_controller.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_depth_controller_if.sv
// Step-request / preset / colour-value bus of the per-channel depth controller.
interface rgb_depth_controller_if #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned WIDTH    = 3
);
    logic [CHANNELS-1:0]       stepUp;
    logic [CHANNELS-1:0]       stepDown;
    logic                      wrapMode;
    logic                      load;
    logic [CHANNELS*WIDTH-1:0] loadValue;
    logic [CHANNELS*WIDTH-1:0] rgbDepth;
    logic [CHANNELS-1:0]       atMax;
    logic [CHANNELS-1:0]       atMin;

    // Request/preset source side.
    modport master (
        output stepUp, stepDown, wrapMode, load, loadValue,
        input  rgbDepth, atMax, atMin
    );

    // Controller side.
    modport slave (
        input  stepUp, stepDown, wrapMode, load, loadValue,
        output rgbDepth, atMax, atMin
    );
endinterface

// File: rtl/rgb_depth_controller.sv
// Per-channel colour-depth controller: one WIDTH-bit intensity register per
// channel, stepped up/down with hold-to-repeat, wrap/saturate and preset load.
module rgb_depth_controller #(
    parameter int unsigned CHANNELS      = 3,
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned RESET_VALUE   = 0,
    parameter int unsigned REPEAT_DELAY  = 8,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    rgb_depth_controller_if.slave bus
);

    localparam int unsigned MAX_COUNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [WIDTH-1:0] CH_MAX      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CH_MIN      = '0;
    localparam logic [WIDTH-1:0] CH_RESET    = WIDTH'(RESET_VALUE);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } channelState_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : gChannel
        channelState_t    state, stateNext;
        logic             dirUp, dirUpNext;
        logic [CNT_W-1:0] count, countNext;
        logic [WIDTH-1:0] value, valueNext;
        logic [WIDTH-1:0] stepped;
        logic             reqValid;
        logic             reqUp;
        logic             holdOk;
        logic             doStep;

        // Exactly one of up/down forms a request; a held request must keep its direction.
        assign reqValid = bus.stepUp[i] ^ bus.stepDown[i];
        assign reqUp    = bus.stepUp[i];
        assign holdOk   = reqValid && (reqUp == dirUp);

        // State register: FSM, latched direction, repeat counter and channel value.
        always_ff @(posedge clock) begin
            if (reset) begin
                state <= IDLE;
                dirUp <= 1'b0;
                count <= '0;
                value <= CH_RESET;
            end else begin
                state <= stateNext;
                dirUp <= dirUpNext;
                count <= countNext;
                value <= valueNext;
            end
        end

        // Next-state logic; load forces every channel back to IDLE.
        always_comb begin
            stateNext = state;
            if (bus.load) begin
                stateNext = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (reqValid) stateNext = DELAY;
                    end
                    DELAY: begin
                        if (!holdOk)                  stateNext = IDLE;
                        else if (count == DELAY_LAST) stateNext = REPEAT;
                    end
                    REPEAT: begin
                        if (!holdOk) stateNext = IDLE;
                    end
                    default: stateNext = IDLE;
                endcase
            end
        end

        // Outputs of the FSM: step strobe, counter and direction updates.
        always_comb begin
            doStep    = 1'b0;
            dirUpNext = dirUp;
            countNext = count;
            if (bus.load) begin
                countNext = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (reqValid) begin
                            doStep    = 1'b1;
                            dirUpNext = reqUp;
                            countNext = '0;
                        end
                    end
                    DELAY: begin
                        if (!holdOk) begin
                            countNext = '0;
                        end else if (count == DELAY_LAST) begin
                            doStep    = 1'b1;
                            countNext = '0;
                        end else begin
                            countNext = count + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!holdOk) begin
                            countNext = '0;
                        end else if (count == PERIOD_LAST) begin
                            doStep    = 1'b1;
                            countNext = '0;
                        end else begin
                            countNext = count + CNT_W'(1);
                        end
                    end
                    default: countNext = '0;
                endcase
            end
        end

        // Step arithmetic with wrap or saturate at the limits, then value select.
        always_comb begin
            stepped = value;
            if (reqUp) begin
                if (value == CH_MAX) stepped = bus.wrapMode ? CH_MIN : CH_MAX;
                else                 stepped = value + WIDTH'(1);
            end else begin
                if (value == CH_MIN) stepped = bus.wrapMode ? CH_MAX : CH_MIN;
                else                 stepped = value - WIDTH'(1);
            end

            valueNext = value;
            if (bus.load)   valueNext = bus.loadValue[i*WIDTH +: WIDTH];
            else if (doStep) valueNext = stepped;
        end

        assign bus.rgbDepth[i*WIDTH +: WIDTH] = value;
        assign bus.atMax[i]                   = (value == CH_MAX);
        assign bus.atMin[i]                   = (value == CH_MIN);
    end

endmodule

// File: tb/tb_rgb_depth_controller.sv
// Bench for rgb_depth_controller: directed scenarios plus randomized traffic
// against a press-age reference model.
module tb_rgb_depth_controller;

    localparam int CH   = 3;
    localparam int W    = 3;
    localparam int RV   = 0;
    localparam int RD   = 4;
    localparam int RP   = 2;
    localparam int MAXV = (1 << W) - 1;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    rgb_depth_controller_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    rgb_depth_controller #(
        .CHANNELS     (CH),
        .WIDTH        (W),
        .RESET_VALUE  (RV),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int testsRun  = 0;
    int failCount = 0;

    // Model: value and edges elapsed since the current press (-1 = no press).
    int mVal [CH];
    int mAge [CH];
    int mDir [CH];

    function automatic bit stepsAt(input int age);
        return (age == 0) || (age == RD) || (age > RD && ((age - RD) % RP) == 0);
    endfunction

    function automatic int applyStep(input int v, input int dir, input bit wrap);
        if (dir > 0) return (v == MAXV) ? (wrap ? 0 : MAXV) : v + 1;
        else         return (v == 0)    ? (wrap ? MAXV : 0) : v - 1;
    endfunction

    task automatic modelEdge();
        for (int c = 0; c < CH; c++) begin
            if (reset) begin
                mVal[c] = RV;
                mAge[c] = -1;
            end else if (bus.load) begin
                mVal[c] = int'(bus.loadValue >> (c * W)) & MAXV;
                mAge[c] = -1;
            end else if (bus.stepUp[c] == bus.stepDown[c]) begin
                mAge[c] = -1;
            end else begin
                int d;
                d = bus.stepUp[c] ? 1 : -1;
                if (mAge[c] < 0) begin
                    mAge[c] = 0;
                    mDir[c] = d;
                end else if (d != mDir[c]) begin
                    mAge[c] = -2;
                end else begin
                    mAge[c] = mAge[c] + 1;
                end
                if (mAge[c] >= 0) begin
                    if (stepsAt(mAge[c])) mVal[c] = applyStep(mVal[c], d, bus.wrapMode);
                end else begin
                    mAge[c] = -1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int chan(input int c);
        return int'(bus.rgbDepth >> (c * W)) & MAXV;
    endfunction

    task automatic checkModel(input string tag);
        int expDepth;
        int expMax;
        int expMin;
        expDepth = 0;
        expMax   = 0;
        expMin   = 0;
        for (int c = 0; c < CH; c++) begin
            expDepth = expDepth | (mVal[c] << (c * W));
            if (mVal[c] == MAXV) expMax = expMax | (1 << c);
            if (mVal[c] == 0)    expMin = expMin | (1 << c);
        end
        check({tag, ".depth"}, int'(bus.rgbDepth), expDepth);
        check({tag, ".atMax"}, int'(bus.atMax), expMax);
        check({tag, ".atMin"}, int'(bus.atMin), expMin);
    endtask

    task automatic tick(input string tag);
        modelEdge();
        @(posedge clock);
        #1;
        checkModel(tag);
    endtask

    // One-cycle request followed by one quiet cycle.
    task automatic pulse(input logic [CH-1:0] up, input logic [CH-1:0] dn, input string tag);
        bus.stepUp   = up;
        bus.stepDown = dn;
        tick(tag);
        bus.stepUp   = '0;
        bus.stepDown = '0;
        tick({tag, ".gap"});
    endtask

    initial begin
        int holdExp [10];
        int revExp  [5];
        int rstExp  [11];
        holdExp = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};
        revExp  = '{1, 1, 1, 1, 2};
        rstExp  = '{1, 1, 1, 0, 1, 1, 1, 1, 2, 2, 3};

        for (int c = 0; c < CH; c++) begin
            mVal[c] = RV;
            mAge[c] = -1;
            mDir[c] = 1;
        end
        reset         = 1'b1;
        bus.stepUp    = '0;
        bus.stepDown  = '0;
        bus.wrapMode  = 1'b0;
        bus.load      = 1'b0;
        bus.loadValue = '0;

        tick("reset0");
        tick("reset1");
        check("resetDepth", int'(bus.rgbDepth), 0);
        check("resetAtMin", int'(bus.atMin), 7);
        check("resetAtMax", int'(bus.atMax), 0);
        reset = 1'b0;

        pulse(3'b001, 3'b000, "pulseUp0");
        check("pulseCh0", chan(0), 1);
        check("pulseCh1", chan(1), 0);
        check("pulseCh2", chan(2), 0);

        bus.stepUp = 3'b010;
        for (int e = 0; e < 10; e++) begin
            tick("holdUp1");
            check($sformatf("holdCh1.e%0d", e), chan(1), holdExp[e]);
        end
        bus.stepUp = '0;
        for (int e = 0; e < 10; e++) tick("release1");
        check("releaseCh1", chan(1), 4);

        bus.wrapMode  = 1'b0;
        bus.load      = 1'b1;
        bus.loadValue = {3'd7, 3'd4, 3'd1};
        bus.stepUp    = 3'b111;
        tick("load");
        bus.load   = 1'b0;
        bus.stepUp = '0;
        check("loadDepth", int'(bus.rgbDepth), 9'o741);
        tick("loadGap");

        pulse(3'b100, 3'b000, "satUp2");
        check("satCh2", chan(2), 7);
        check("satAtMax2", int'(bus.atMax[2]), 1);
        bus.wrapMode = 1'b1;
        pulse(3'b100, 3'b000, "wrapUp2");
        check("wrapCh2", chan(2), 0);
        check("wrapAtMin2", int'(bus.atMin[2]), 1);

        bus.load      = 1'b1;
        bus.loadValue = {3'd0, 3'd4, 3'd0};
        tick("load0");
        bus.load = 1'b0;
        pulse(3'b000, 3'b001, "wrapDown0");
        check("wrapDownCh0", chan(0), 7);
        bus.stepUp   = 3'b001;
        bus.stepDown = 3'b001;
        for (int e = 0; e < 6; e++) tick("bothHeld0");
        check("bothHeldCh0", chan(0), 7);
        bus.stepUp   = '0;
        bus.stepDown = '0;

        bus.load      = 1'b1;
        bus.loadValue = '0;
        tick("loadZero");
        bus.load   = 1'b0;
        bus.stepUp = 3'b001;
        for (int e = 0; e < 5; e++) begin
            tick("revUp");
            check($sformatf("revCh0.e%0d", e), chan(0), revExp[e]);
        end
        bus.stepUp   = '0;
        bus.stepDown = 3'b001;
        tick("revSwap");
        check("revCh0.e5", chan(0), 2);
        tick("revDown");
        check("revCh0.e6", chan(0), 1);
        bus.stepDown = '0;
        tick("revGap");

        bus.load      = 1'b1;
        bus.loadValue = '0;
        tick("loadZero2");
        bus.load   = 1'b0;
        bus.stepUp = 3'b010;
        for (int e = 0; e < 11; e++) begin
            reset = (e == 3);
            tick("rstHold");
            check($sformatf("rstCh1.e%0d", e), chan(1), rstExp[e]);
        end
        reset      = 1'b0;
        bus.stepUp = '0;
        tick("rstGap");

        for (int n = 0; n < 600; n++) begin
            bus.load = 1'b0;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    bus.stepUp[c]   = 1'($urandom_range(0, 1));
                    bus.stepDown[c] = 1'($urandom_range(0, 1));
                end
            end
            if ($urandom_range(0, 19) == 0) bus.wrapMode = ~bus.wrapMode;
            if ($urandom_range(0, 39) == 0) begin
                bus.load      = 1'b1;
                bus.loadValue = (CH*W)'($urandom);
            end
            reset = ($urandom_range(0, 99) == 0);
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
